ram_sp_clr: RTL

Parametrised single-port synchronous RAM. It is the successor to the team's fixed 8x8 RAM, and adds:
- configurable data width and depth
- selectable read-during-write mode
- an optional output pipeline register
- a read-valid strobe
- a hardware clear sequencer that initialises every location after reset or on request

It serves as general scratch/buffer storage for datapath blocks in the lab designs.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_sp_clr.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the single-port clearable RAM.
// Read-during-write mode selectors and the clear-sequencer FSM states.
package ram_pkg;

  localparam int RD_NO_CHANGE   = 0;
  localparam int RD_READ_FIRST  = 1;
  localparam int RD_WRITE_FIRST = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_sp_clr.sv
// Single-port sync RAM with hardware clear sweep after reset or on clr request.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); one result per cycle for back-to-back reads.
// No backpressure: accesses are silently dropped while busy or when clr is asserted.
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 3,
  parameter int                 RD_MODE = RD_NO_CHANGE,
  parameter int                 OUT_REG = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] dIn,
  output logic [DATA_W-1:0] dOut,
  output logic              rdValid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_adr_q, clr_adr_d;
  logic              clr_wr;
  logic              acc, acc_wr, acc_rd;
  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_dat_q, s1_dat_d;

  always_comb begin
    state_d   = state_q;
    clr_adr_d = clr_adr_q;
    clr_wr    = 1'b0;
    if (clr) begin
      state_d   = CLEAR;
      clr_adr_d = '0;
    end else if (state_q == CLEAR) begin
      clr_wr    = 1'b1;
      clr_adr_d = clr_adr_q + 1'b1;
      if (clr_adr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = IDLE;
      end
    end
  end

  // clr outranks any access presented in the same cycle
  assign acc    = (state_q == IDLE) && !clr && en;
  assign acc_wr = acc && writeEn;
  assign acc_rd = acc && !writeEn;
  assign busy   = (state_q == CLEAR);

  always_comb begin
    s1_vld_d = 1'b0;
    s1_dat_d = s1_dat_q;
    if (acc_rd) begin
      s1_vld_d = 1'b1;
      s1_dat_d = mem[adr];
    end else if (acc_wr) begin
      if (RD_MODE == RD_READ_FIRST) begin
        s1_vld_d = 1'b1;
        s1_dat_d = mem[adr];
      end else if (RD_MODE == RD_WRITE_FIRST) begin
        s1_vld_d = 1'b1;
        s1_dat_d = dIn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_adr_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_adr_q <= clr_adr_d;
      s1_vld_q  <= s1_vld_d;
      s1_dat_q  <= s1_dat_d;
    end
  end

  // Storage is deliberately left unreset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_adr_q] <= CLR_VAL;
    end else if (acc_wr) begin
      mem[adr] <= dIn;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s2_vld_q;
      logic [DATA_W-1:0] s2_dat_q;

      // A clr landing while a result sits in stage 1 kills that result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q && !clr;
          if (s1_vld_q && !clr) begin
            s2_dat_q <= s1_dat_q;
          end
        end
      end

      assign dOut    = s2_dat_q;
      assign rdValid = s2_vld_q;
    end else begin : g_noreg
      assign dOut    = s1_dat_q;
      assign rdValid = s1_vld_q;
    end
  endgenerate

endmodule
